// File: rtl/pc_unit.sv
// pc_unit: fetch-address register with prioritised next-PC selection and a circular return-address stack.
// Optional macro PC_MISALIGN_CHECK_EN redirects misaligned branch/jump/return targets to the exception vector.
module pc_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_0080,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             exc,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic             call,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf,
  output logic             misalign
);

  localparam int unsigned      PW       = $clog2(RAS_DEPTH);
  localparam int unsigned      CW       = PW + 1;
  localparam logic [WIDTH-1:0] RST_V    = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] EXC_V    = WIDTH'(EXC_VEC);
  localparam logic [WIDTH-1:0] PC_INC   = WIDTH'(32'd4);
  localparam logic [CW-1:0]    FULL_CNT = CW'(RAS_DEPTH);

`ifdef PC_MISALIGN_CHECK_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_next_s;
  logic [WIDTH-1:0] pc_inc_s;
  logic [WIDTH-1:0] tgt_s;
  logic [WIDTH-1:0] ras_top_s;
  logic [WIDTH-1:0] ras_r [RAS_DEPTH];
  logic [PW-1:0]    top_r;
  logic [CW-1:0]    cnt_r;
  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic             swap_s;
  logic             chk_s;
  logic             unf_s;
  logic             mis_s;
  logic             ovf_r;
  logic             unf_r;
  logic             mis_r;

  assign pc_inc_s  = pc_r + PC_INC;
  assign ras_top_s = ras_r[top_r];
  assign empty_s   = (cnt_r == {CW{1'b0}});
  assign full_s    = (cnt_r == FULL_CNT);

  // Next-PC priority select and RAS operation decode
  always_comb begin
    pc_next_s = pc_inc_s;
    tgt_s     = pc_inc_s;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    swap_s    = 1'b0;
    chk_s     = 1'b0;
    unf_s     = 1'b0;
    mis_s     = 1'b0;
    if (exc) begin
      pc_next_s = EXC_V;
    end else if (stall) begin
      pc_next_s = pc_r;
    end else begin
      if (ret && call) begin
        chk_s = 1'b1;
        if (empty_s) begin
          tgt_s  = jmp_target;
          push_s = 1'b1;
          unf_s  = 1'b1;
        end else begin
          tgt_s  = ras_top_s;
          swap_s = 1'b1;
        end
      end else if (ret) begin
        // A return with nothing stacked falls through sequentially
        if (empty_s) begin
          tgt_s = pc_inc_s;
          unf_s = 1'b1;
        end else begin
          tgt_s = ras_top_s;
          pop_s = 1'b1;
          chk_s = 1'b1;
        end
      end else if (call) begin
        tgt_s  = jmp_target;
        push_s = 1'b1;
        chk_s  = 1'b1;
      end else if (jmp) begin
        tgt_s = jmp_target;
        chk_s = 1'b1;
      end else if (br_taken) begin
        tgt_s = br_target;
        chk_s = 1'b1;
      end else begin
        tgt_s = pc_inc_s;
      end
      if (MIS_EN && chk_s && (tgt_s[1:0] != 2'b00)) begin
        pc_next_s = EXC_V;
        mis_s     = 1'b1;
      end else begin
        pc_next_s = tgt_s;
      end
    end
  end

  // PC, RAS pointer/count and status flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r  <= RST_V;
      top_r <= {PW{1'b0}};
      cnt_r <= {CW{1'b0}};
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
      mis_r <= 1'b0;
    end else begin
      pc_r  <= pc_next_s;
      unf_r <= unf_s;
      mis_r <= mis_s;
      if (push_s) begin
        top_r <= top_r + PW'(1'b1);
        if (full_s) begin
          ovf_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + CW'(1'b1);
        end
      end else if (pop_s) begin
        top_r <= top_r - PW'(1'b1);
        cnt_r <= cnt_r - CW'(1'b1);
      end
    end
  end

  // RAS storage; when full, a push lands on the oldest slot
  always_ff @(posedge clk) begin
    if (push_s) begin
      ras_r[top_r + PW'(1'b1)] <= pc_inc_s;
    end else if (swap_s) begin
      ras_r[top_r] <= pc_inc_s;
    end
  end

  assign pc        = pc_r;
  assign pc_next   = pc_next_s;
  assign ras_empty = empty_s;
  assign ras_full  = full_s;
  assign ras_ovf   = ovf_r;
  assign ras_unf   = unf_r;
  assign misalign  = mis_r;

endmodule
